pipe_hazard_ctrl: RTL

Central stall/flush controller for the 5-stage 554 CPU pipeline. It drives the stall and flush inputs of the IF/ID register, bubbles ID/EX, and freezes the PC and EX/MEM. Sources of control:
- load-use hazards
- taken branches resolved in EX
- multi-cycle data-memory waits
- instruction-fetch not ready
- HALT

---
 rtl/hazard_pkg.sv | 10 +
 rtl/load_use_detect.sv | 19 +
 rtl/pipe_hazard_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard controller
package hazard_pkg;
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } hz_state_t;
    localparam int REG_IDX_W = 5;
    localparam logic [31:0] NOP_INSTR = 32'h00000000;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: combinational load-use hazard comparator
//   id_rs1/id_rs2, id_uses_rs1/id_uses_rs2 : operands of the ID instruction
//   ex_memread, ex_rd                      : load in EX and its destination
//   load_use                               : ID needs a value the EX load has not produced yet
module load_use_detect #(
    parameter int IDX_W = 5
) (
    input  logic [IDX_W-1:0] id_rs1,
    input  logic [IDX_W-1:0] id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_memread,
    input  logic [IDX_W-1:0] ex_rd,
    output logic             load_use
);
    // x0 is hard-wired zero, so a match on it is never a real dependency
    assign load_use = ex_memread && (ex_rd != '0) &&
                      ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush controller for the 5-stage pipeline
//   inputs : ID operands, EX load/branch info, mem_busy, imem_ready, halt_in
//   outputs: pc_stall, ifid_stall, ifid_flush, idex_bubble, pipe_freeze (Mealy),
//            halted, mem_timeout (sticky), stall_cycles/flush_count statistics
//   Statistics counters exist only when HAZARD_STATS_EN is defined; otherwise tied to 0.
module pipe_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int NUM_REGS     = 32,
    parameter int WAIT_TIMEOUT = 255,
    parameter int CNT_W        = 32,
    localparam int IDX_W       = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] id_rs1,
    input  logic [IDX_W-1:0] id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_memread,
    input  logic [IDX_W-1:0] ex_rd,
    input  logic             ex_branch_taken,
    input  logic             mem_busy,
    input  logic             imem_ready,
    input  logic             halt_in,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pipe_freeze,
    output logic             halted,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);
    localparam int WC_W = $clog2(WAIT_TIMEOUT + 1);

    hz_state_t       state, state_nxt;
    logic [WC_W-1:0] wait_cnt, wait_nxt;
    logic            load_use;

    load_use_detect #(.IDX_W(IDX_W)) u_load_use_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_memread  (ex_memread),
        .ex_rd       (ex_rd),
        .load_use    (load_use)
    );

    // Outputs are gated by rst_n so everything reads 0 while reset is held
    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_freeze = 1'b0;
        state_nxt   = state;
        wait_nxt    = wait_cnt;
        if (rst_n) begin
            case (state)
                RUN: begin
                    if (mem_busy) begin
                        {pc_stall, ifid_stall, pipe_freeze} = 3'b111;
                        state_nxt = MEM_WAIT;
                        wait_nxt  = WC_W'(1);
                    end else if (ex_branch_taken) begin
                        {ifid_flush, idex_bubble} = 2'b11;
                    end else if (load_use) begin
                        {pc_stall, ifid_stall, idex_bubble} = 3'b111;
                    end else if (halt_in) begin
                        {pc_stall, ifid_stall, idex_bubble} = 3'b111;
                        state_nxt = HALT;
                    end else if (!imem_ready) begin
                        {pc_stall, ifid_flush} = 2'b11;
                    end
                end
                MEM_WAIT: begin
                    if (mem_busy) begin
                        {pc_stall, ifid_stall, pipe_freeze} = 3'b111;
                        wait_nxt = (wait_cnt == WC_W'(WAIT_TIMEOUT)) ? wait_cnt : wait_cnt + WC_W'(1);
                    end else begin
                        state_nxt = RUN;
                        wait_nxt  = '0;
                    end
                end
                HALT: begin
                    {pc_stall, ifid_stall, idex_bubble} = 3'b111;
                    pipe_freeze = mem_busy;
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            // wait_nxt equals the number of consecutive busy cycles seen so far
            if (state_nxt == MEM_WAIT && wait_nxt == WC_W'(WAIT_TIMEOUT))
                mem_timeout <= 1'b1;
        end
    end

    assign halted = (state == HALT);

`ifdef HAZARD_STATS_EN
    // A flush together with ex_branch_taken can only come from the branch rule
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            stall_cycles <= stall_cycles + CNT_W'(pc_stall);
            flush_count  <= flush_count + CNT_W'(ifid_flush && ex_branch_taken);
        end
    end
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif
endmodule
